traffic_phase_scheduler: RTL
============================

# traffic_phase_scheduler

Timed phase scheduler for the main/county intersection. It replaces sensor-only stepping with counted minimum green, maximum green, yellow and all-red intervals. It adds a latched pedestrian request served by an all-red walk phase, and an emergency preempt that forces and holds main-road green. Light outputs use the same 8-bit ASCII light codes as the existing signal block: G = 0x47, Y = 0x59, R = 0x52.

## Interface
- MIN_GREEN, 8: minimum cycles in either green phase
- MAX_GREEN, 20: maximum cycles in county green; must be ≥ MIN_GREEN
- YELLOW, 3: cycles in either yellow phase
- ALL_RED, 2: cycles in each all-red clearance phase
- WALK, 6: cycles in pedestrian phase
- CNT_W, 5: phase timer width; 2^CNT_W must exceed every timing parameter above
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; resets all state
- x  in  1  county-road vehicle sensor, level, synchronous to clk
- ped_req  in  1  pedestrian button, synchronous; any high cycle registers a request
- emerg  in  1  emergency preempt, level, synchronous
- main_road  out  8  main-road light code (G/Y/R)
- county_road  out  8  county-road light code (G/Y/R)
- walk  out  1  pedestrian walk lamp
- phase  out  3  current phase: MG=0, MY=1, AR1=2, CG=3, CY=4, AR2=5, PED=6
- ped_pending  out  1  latched pedestrian request

## Operation
- Phase lights:
  - MG: main G, county R
  - MY: main Y, county R
  - AR1/AR2/PED: both R
  - CG: main R, county G
  - CY: main R, county Y
  - walk = 1 only in PED
- Timer t: resets to 0 on every phase change, otherwise increments, saturating at 2^CNT_W−1. "t==N−1" means the phase has lasted N cycles.
- MG:
  - emerg=1: stay.
  - Else → MY when t ≥ MIN_GREEN−1 and (x or ped_pending).
  - No upper limit; main road rests in MG.
- MY: → AR1 at t==YELLOW−1.
- AR1: at t==ALL_RED−1, take the first that applies:
  - emerg → MG
  - ped_pending → PED
  - x → CG
  - else → MG
- CG:
  - emerg → CY next edge, ignoring MIN_GREEN.
  - Else → CY when t ≥ MIN_GREEN−1 and (x==0 or ped_pending or t==MAX_GREEN−1).
- CY: → AR2 at t==YELLOW−1. emerg does not shorten yellow.
- AR2: at t==ALL_RED−1:
  - ped_pending and !emerg → PED
  - else → MG
- PED:
  - → MG at t==WALK−1.
  - emerg → MG next edge (walk aborted).
- ped_pending:
  - Set by ped_req=1.
  - Cleared on the edge that enters PED.
  - If set and clear occur on the same edge, set wins, so a press on the entry cycle is kept for the next round.
- Unused phase encoding 7: → MG next edge. Outputs decode as MG while in 7.

## Timing
- Reset values: phase=MG, t=0, ped_pending=0, main_road=0x47, county_road=0x52, walk=0.
- State, t, ped_pending and all outputs are registered and change only on the clk rising edge, or asynchronously on reset.
- Outputs always match the phase value on the same cycle; there is no extra output latency.
- Inputs are sampled at the rising edge. A decision made at edge k shows on the outputs after edge k.
- Reset mid-phase returns to MG immediately and drops any pending request. No yellow is inserted.
- Phase durations with defaults:
  - MG ≥ 8
  - MY = 3
  - AR1 = 2
  - CG between 8 and 20
  - CY = 3
  - AR2 = 2
  - PED = 6
- Exception: emergency aborts may cut CG or PED short, to as little as 1 cycle.
- Green is never followed directly by red for the same road, and no green is ever shown while walk=1.

## Test plan
- Reset, then x=0, ped_req=0 for 50 cycles → phase stays 0, main_road=0x47, county_road=0x52, walk=0 throughout.
- Release reset, hold x=1 → 8 cycles MG, 3 MY, 2 AR1, 20 CG (MAX_GREEN cut), 3 CY, 2 AR2, then MG. Check t ≥ MIN_GREEN honored in MG again.
- x=0, single-cycle ped_req at cycle 2 → ped_pending=1 at cycle 3, MY after cycle 7, AR1, PED for 6 cycles with walk=1 and both roads 0x52, then MG. ped_pending clears on PED entry.
- In CG at t=2, assert emerg → CY next edge, 3 CY, 2 AR2, MG. Stays MG while emerg=1 even with x=1 and ped_pending=1. After emerg drops, PED is served before CG.
- ped_req pulsed on the PED entry edge → ped_pending stays 1, and a second PED follows the next MG/MY/AR1 sequence.
- Assert reset for 1 cycle mid-CY → outputs return to 0x47/0x52 asynchronously, ped_pending=0, and the normal MG minimum of 8 cycles restarts.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Timed phase scheduler for the main/county intersection: counted green, yellow and
// all-red intervals, a latched pedestrian walk phase and main-road emergency preempt.
module traffic_phase_scheduler #(
   parameter int MIN_GREEN = 8,
   parameter int MAX_GREEN = 20,
   parameter int YELLOW    = 3,
   parameter int ALL_RED   = 2,
   parameter int WALK      = 6,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       x,
   input  logic       ped_req,
   input  logic       emerg,
   output logic [7:0] main_road,
   output logic [7:0] county_road,
   output logic       walk,
   output logic [2:0] phase,
   output logic       ped_pending
);

   // state | meaning
   // MG    | main green, county red; rests here
   // MY    | main yellow
   // AR1   | all red after main; chooses next phase
   // CG    | county green, bounded by MIN/MAX green
   // CY    | county yellow
   // AR2   | all red after county
   // PED   | all red with walk lamp
   typedef enum logic [2:0] {
      MG  = 3'd0,
      MY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5,
      PED = 3'd6
   } phase_e;

   localparam logic [7:0] LT_G = 8'h47;
   localparam logic [7:0] LT_Y = 8'h59;
   localparam logic [7:0] LT_R = 8'h52;

   // Terminal counts are N-1: t==N-1 means the phase has lasted N cycles.
   localparam logic [CNT_W-1:0] T_MIN  = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALL_RED - 1);
   localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK - 1);
   localparam logic [CNT_W-1:0] T_SAT  = '1;

   phase_e           state, state_nx;
   logic [CNT_W-1:0] t;
   logic             ped_clr;

   always_comb begin
      state_nx = state;
      case (state)
         MG:  if (!emerg && t >= T_MIN && (x || ped_pending)) state_nx = MY;
         MY:  if (t == T_YEL) state_nx = AR1;
         AR1: if (t == T_AR) begin
                 if (emerg)            state_nx = MG;
                 else if (ped_pending) state_nx = PED;
                 else if (x)           state_nx = CG;
                 else                  state_nx = MG;
              end
         CG:  if (emerg || (t >= T_MIN && (!x || ped_pending || t == T_MAX))) state_nx = CY;
         CY:  if (t == T_YEL) state_nx = AR2;
         AR2: if (t == T_AR) state_nx = (ped_pending && !emerg) ? PED : MG;
         PED: if (emerg || t == T_WALK) state_nx = MG;
         default: state_nx = MG;
      endcase
   end

   assign ped_clr = (state_nx == PED) && (state != PED);
   assign phase   = state;

   // Lights are decoded from the next phase so they change on the same edge as phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= MG;
         t           <= '0;
         ped_pending <= 1'b0;
         main_road   <= LT_G;
         county_road <= LT_R;
         walk        <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx != state) t <= '0;
         else if (t != T_SAT)   t <= t + CNT_W'(1);
         ped_pending <= ped_req || (ped_pending && !ped_clr);
         walk        <= (state_nx == PED);
         case (state_nx)
            MY:           begin main_road <= LT_Y; county_road <= LT_R; end
            AR1, AR2, PED: begin main_road <= LT_R; county_road <= LT_R; end
            CG:           begin main_road <= LT_R; county_road <= LT_G; end
            CY:           begin main_road <= LT_R; county_road <= LT_Y; end
            default:      begin main_road <= LT_G; county_road <= LT_R; end
         endcase
      end
   end

endmodule
